video_timing_gen: RTL and testbench
===================================

Name: video_timing_gen

Overview:
- Master raster timing source for the video output path.
- Generates hs/vs/de plus pixel coordinates that drive downstream pixel consumers (delay/Sobel stage, frame-buffer read, HDMI TX).
- Opposite end of the hs/vs/de interface: this block originates the stream that line-buffer/filter stages consume.
- Optional built-in colour-bar source, usable for bring-up without camera or DDR.

Parameters:
- H_ACTIVE, 1024, active pixels per line
- H_FP, 24, horizontal front porch (clocks)
- H_SYNC, 136, horizontal sync width (clocks)
- H_BP, 160, horizontal back porch (clocks)
- V_ACTIVE, 768, active lines per frame
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vertical sync width (lines)
- V_BP, 29, vertical back porch (lines)
- HS_POL, 0, hs active level (0 = active-low)
- VS_POL, 0, vs active level
- DATA_WIDTH, 24, pixel width, RGB888 {R,G,B}

Ports:
- video_clk  in  1  pixel clock (65 MHz for the default 1024x768@60)
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  run enable; sampled only at the frame boundary
- hs  out  1  horizontal sync, polarity set by HS_POL
- vs  out  1  vertical sync, polarity set by VS_POL
- de  out  1  active video
- x  out  12  active pixel column, 0..H_ACTIVE-1; 0 outside active
- y  out  12  active line, 0..V_ACTIVE-1; 0 outside active
- frame_start  out  1  one-clock pulse coincident with de of pixel (0,0)
- vout_data  out  DATA_WIDTH  test pattern; all zero unless VIDEO_TPG_EN is defined

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1344); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (806).
- Counters:
  - h_cnt 0..H_TOTAL-1, advances every clock while running.
  - v_cnt advances when h_cnt wraps from H_TOTAL-1 to 0, then wraps V_TOTAL-1 -> 0.
- Segment order per axis: active, front porch, sync, back porch.
- Decode:
  - hs active iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vs active iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC.
  - vs changes aligned to the h_cnt=0 edge, not to hs.
  - de = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- All outputs are registered decodes of the current counter values, one clock of latency. Outputs for counter state (h,v) appear the clock after the counters hold (h,v).
- x/y: equal h_cnt/v_cnt while de; forced to 0 otherwise.
- Reset (rst_n low, async):
  - h_cnt=v_cnt=0; state IDLE.
  - de=0, frame_start=0, x=y=0, vout_data=0.
  - hs=~HS_POL, vs=~VS_POL (inactive).
- FSM:
  - IDLE: counters held at 0, outputs inactive. Goes to RUN on the clock where en=1.
  - RUN: counters free-run. When h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1 and en=0, go to IDLE instead of wrapping.
  - en deasserted mid-frame: the current frame always completes; no truncated frames.
- First frame after entering RUN: counters start at (0,0); the output shows de=1 and frame_start=1 one clock after the RUN transition.
- rst_n asserted mid-frame: immediate async return to reset values. After release, restart from IDLE.
- Edge case: parameter sets with any segment width = 0 are illegal. Flag with an elaboration-time check.

Optional Feature:
- Macro: VIDEO_TPG_EN.
- Defined:
  - vout_data carries 8 vertical colour bars, each H_ACTIVE/8 wide.
  - Bar order: white, yellow, cyan, green, magenta, red, blue, black (components 8'hFF/8'h00).
  - Registered and aligned with de; zero when de=0.
- Undefined: vout_data tied to 0; no pattern logic synthesised.

Decomposition:
- Package video_timing_pkg:
  - 1024x768@60 timing constants.
  - H_TOTAL/V_TOTAL derivation functions.
  - IDLE/RUN state encoding.
  - Colour-bar RGB constants.
- Sub-module video_timing_axis:
  - Parameterised counter + segment decoder (active/sync flags, wrap pulse).
  - Instantiated twice: horizontal, clocked every cycle; vertical, enabled by the horizontal wrap pulse.

Test Plan:
1. Reset then en=1, default params: first de rising edge 1 clock after RUN with frame_start=1, x=0, y=0. Measure hs period = 1344 clocks, hs low width = 136, de high 1024 per line.
2. Full frame: count exactly 768 de lines; vs low for 6 lines (8064 clocks); frame period = 1083264 clocks; consecutive frame_start pulses 1083264 apart.
3. Small params (H 8/1/2/1, V 4/1/1/1, HS_POL=1): hs high at h_cnt 9..10; x sequence 0..7 per line; y 0..3; totals 12x7.
4. Drop en at line 100 mid-frame: frame runs to completion, then outputs park at de=0, hs/vs inactive. Re-raise en: restart with frame_start after 1 clock.
5. Assert rst_n low at h_cnt=500, v_cnt=300: outputs go to reset values without waiting for a clock edge. After release, no activity until en=1.
6. VIDEO_TPG_EN defined: at y=0, x=0 -> vout_data=24'hFFFFFF; x=128 -> 24'hFFFF00; x=1023 -> 24'h000000; vout_data=0 during blanking.

Source files
------------

// File: rtl/video_timing_pkg.sv
// Shared raster constants, state encoding and colour-bar palette for the video timing generator.
// Defaults describe 1024x768@60 on a 65 MHz pixel clock.
package video_timing_pkg;

  localparam int CNT_W = 12;

  localparam int DEF_H_ACTIVE = 1024;
  localparam int DEF_H_FP     = 24;
  localparam int DEF_H_SYNC   = 136;
  localparam int DEF_H_BP     = 160;
  localparam int DEF_V_ACTIVE = 768;
  localparam int DEF_V_FP     = 3;
  localparam int DEF_V_SYNC   = 6;
  localparam int DEF_V_BP     = 29;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [23:0] RGB_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] RGB_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] RGB_CYAN    = 24'h00FFFF;
  localparam logic [23:0] RGB_GREEN   = 24'h00FF00;
  localparam logic [23:0] RGB_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] RGB_RED     = 24'hFF0000;
  localparam logic [23:0] RGB_BLUE    = 24'h0000FF;
  localparam logic [23:0] RGB_BLACK   = 24'h000000;

  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return axis_total(active, fp, sync, bp);
  endfunction

  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return axis_total(active, fp, sync, bp);
  endfunction

  // Bar indices past the eighth bar (H_ACTIVE not a multiple of 8) fall back to black.
  function automatic logic [23:0] colour_bar(input logic [CNT_W-1:0] idx);
    logic [23:0] rgb;
    rgb = RGB_BLACK;
    if (idx <= CNT_W'(7)) begin
      case (idx[2:0])
        3'd0: rgb = RGB_WHITE;
        3'd1: rgb = RGB_YELLOW;
        3'd2: rgb = RGB_CYAN;
        3'd3: rgb = RGB_GREEN;
        3'd4: rgb = RGB_MAGENTA;
        3'd5: rgb = RGB_RED;
        3'd6: rgb = RGB_BLUE;
        3'd7: rgb = RGB_BLACK;
      endcase
    end
    return rgb;
  endfunction

endpackage

// File: rtl/video_timing_axis.sv
// One raster axis: wrapping counter plus active/sync segment decode and a wrap pulse.
// Used once per line (horizontal) and once per frame (vertical, advanced by the line wrap).
module video_timing_axis
  import video_timing_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP
) (
  input  logic             video_clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             adv,
  output logic [CNT_W-1:0] cnt,
  output logic             active,
  output logic             sync,
  output logic             wrap
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [CNT_W-1:0] ACT_END  = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_BEG = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] SYNC_END = CNT_W'(ACTIVE + FP + SYNC);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TOTAL - 1);

  logic last;

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (adv) cnt <= last ? '0 : cnt + 1'b1;
  end

  assign last   = (cnt == LAST_CNT);
  assign wrap   = adv && last;
  assign active = (cnt < ACT_END);
  assign sync   = (cnt >= SYNC_BEG) && (cnt < SYNC_END);

endmodule

// File: rtl/video_timing_gen.sv
// Master raster timing source: hs/vs/de, pixel coordinates and frame_start, all one clock behind the counters.
// Define VIDEO_TPG_EN to drive an 8-bar colour pattern on vout_data; otherwise vout_data is tied to zero.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter int HS_POL     = 0,
  parameter int VS_POL     = 0,
  parameter int DATA_WIDTH = 24
) (
  input  logic                  video_clk,
  input  logic                  rst_n,
  input  logic                  en,
  output logic                  hs,
  output logic                  vs,
  output logic                  de,
  output logic [11:0]           x,
  output logic [11:0]           y,
  output logic                  frame_start,
  output logic [DATA_WIDTH-1:0] vout_data
);

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_params
    $error("video_timing_gen: every timing segment must be at least one unit wide");
  end

  localparam logic HS_ACT = (HS_POL != 0);
  localparam logic VS_ACT = (VS_POL != 0);

  state_t           state, state_nxt;
  logic             run;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             h_act, h_sync, h_wrap;
  logic             v_act, v_sync, v_wrap;
  logic             pix_act;

  logic             hs_p1, vs_p1, de_p1, fs_p1;
  logic [CNT_W-1:0] x_p1, y_p1;

  video_timing_axis #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h_axis (
    .video_clk (video_clk),
    .rst_n     (rst_n),
    .clr       (!run),
    .adv       (run),
    .cnt       (h_cnt),
    .active    (h_act),
    .sync      (h_sync),
    .wrap      (h_wrap)
  );

  video_timing_axis #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v_axis (
    .video_clk (video_clk),
    .rst_n     (rst_n),
    .clr       (!run),
    .adv       (h_wrap),
    .cnt       (v_cnt),
    .active    (v_act),
    .sync      (v_sync),
    .wrap      (v_wrap)
  );

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // en only matters in IDLE and on the last clock of a frame, so frames are never truncated.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (en)              state_nxt = ST_RUN;
      ST_RUN:  if (v_wrap && !en)   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    run = (state == ST_RUN);
  end

  assign pix_act = h_act && v_act;

  // ---- stage p1: registered decode of the current counter values ----
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_p1 <= ~HS_ACT;
      vs_p1 <= ~VS_ACT;
      de_p1 <= 1'b0;
      fs_p1 <= 1'b0;
      x_p1  <= '0;
      y_p1  <= '0;
    end else if (run) begin
      hs_p1 <= h_sync ? HS_ACT : ~HS_ACT;
      vs_p1 <= v_sync ? VS_ACT : ~VS_ACT;
      de_p1 <= pix_act;
      fs_p1 <= (h_cnt == '0) && (v_cnt == '0);
      x_p1  <= pix_act ? h_cnt : '0;
      y_p1  <= pix_act ? v_cnt : '0;
    end else begin
      hs_p1 <= ~HS_ACT;
      vs_p1 <= ~VS_ACT;
      de_p1 <= 1'b0;
      fs_p1 <= 1'b0;
      x_p1  <= '0;
      y_p1  <= '0;
    end
  end

  assign hs          = hs_p1;
  assign vs          = vs_p1;
  assign de          = de_p1;
  assign frame_start = fs_p1;
  assign x           = x_p1;
  assign y           = y_p1;

`ifdef VIDEO_TPG_EN
  localparam int BAR_W = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;
  localparam logic [CNT_W-1:0] BAR_W_C = CNT_W'(BAR_W);

  logic [DATA_WIDTH-1:0] pix_p1;

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n)             pix_p1 <= '0;
    else if (run && pix_act) pix_p1 <= DATA_WIDTH'(colour_bar(h_cnt / BAR_W_C));
    else                    pix_p1 <= '0;
  end

  assign vout_data = pix_p1;
`else
  assign vout_data = '0;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a small raster (H 16/2/3/2, V 5/1/2/1, hs active-high, vs active-low).
module tb_video_timing_gen;

  localparam int HA = 16, HF = 2, HSW = 3, HB = 2;
  localparam int VA = 5,  VF = 1, VSW = 2, VB = 1;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int FRAME = HT * VT;

  logic        video_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        hs, vs, de, frame_start;
  logic [11:0] x, y;
  logic [23:0] vout_data;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(1), .VS_POL(0), .DATA_WIDTH(24)
  ) dut (
    .video_clk   (video_clk),
    .rst_n       (rst_n),
    .en          (en),
    .hs          (hs),
    .vs          (vs),
    .de          (de),
    .x           (x),
    .y           (y),
    .frame_start (frame_start),
    .vout_data   (vout_data)
  );

  always #5 video_clk = ~video_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      if (bad < 40) $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(negedge video_clk);
    #1;
  endtask

  // Reference model: a running flag and a linear position within the frame.
  bit          m_run = 1'b0;
  int          m_idx = 0;
  int          mh, mv;
  logic        e_hs = 1'b0, e_vs = 1'b1, e_de = 1'b0, e_fs = 1'b0;
  logic [11:0] e_x = '0, e_y = '0;
  logic [23:0] e_pix = '0;
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  always @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 1'b0; m_idx = 0;
      e_hs = 1'b0; e_vs = 1'b1; e_de = 1'b0; e_fs = 1'b0;
      e_x = '0; e_y = '0; e_pix = '0;
    end else begin
      mh = m_idx % HT;
      mv = m_idx / HT;
      e_de = m_run && (mh < HA) && (mv < VA);
      e_hs = m_run && (mh >= HA + HF) && (mh < HA + HF + HSW);
      e_vs = !(m_run && (mv >= VA + VF) && (mv < VA + VF + VSW));
      e_fs = m_run && (m_idx == 0);
      e_x  = e_de ? 12'(mh) : 12'd0;
      e_y  = e_de ? 12'(mv) : 12'd0;
`ifdef VIDEO_TPG_EN
      e_pix = e_de ? bars[mh * 8 / HA] : 24'd0;
`else
      e_pix = 24'd0;
`endif
      if (!m_run) begin
        if (en) begin m_run = 1'b1; m_idx = 0; end
      end else if (m_idx == FRAME - 1) begin
        m_idx = 0;
        if (!en) m_run = 1'b0;
      end else begin
        m_idx++;
      end
    end
  end

  always @(negedge video_clk) begin
    if (chk_on)
      chk("cycle", 64'({hs, vs, de, frame_start, x, y, vout_data}),
                   64'({e_hs, e_vs, e_de, e_fs, e_x, e_y, e_pix}));
  end

  initial begin
    int de_cnt, hs_cnt, vs_lo, fs_cnt, lines, rise0, rise1, max_x, max_y;
    logic prev_hs;
    bit found;

    rst_n = 1'b0; en = 1'b0;
    repeat (3) tick();
    chk_on = 1'b1;
    chk("rst_hs", 64'(hs), 64'd0);
    chk("rst_vs", 64'(vs), 64'd1);
    chk("rst_de", 64'({de, frame_start}), 64'd0);
    chk("rst_xy", 64'({x, y}), 64'd0);
    chk("rst_pix", 64'(vout_data), 64'd0);
    rst_n = 1'b1;
    repeat (5) tick();
    chk("idle_de", 64'(de), 64'd0);

    en = 1'b1;
    tick();
    chk("pre_fs", 64'({de, frame_start}), 64'd0);
    tick();
    chk("first_fs", 64'(frame_start), 64'd1);
    chk("first_de", 64'(de), 64'd1);
    chk("first_xy", 64'({x, y}), 64'd0);

    de_cnt = 0; hs_cnt = 0; vs_lo = 0; fs_cnt = 0; lines = 0;
    rise0 = -1; rise1 = -1; max_x = 0; max_y = 0; prev_hs = hs;
    for (int k = 0; k < FRAME; k++) begin
      if (de) de_cnt++;
      if (hs) hs_cnt++;
      if (!vs) vs_lo++;
      if (frame_start) fs_cnt++;
      if (de && x == 12'd0) lines++;
      if (hs && !prev_hs) begin
        if (rise0 < 0) rise0 = k;
        else if (rise1 < 0) rise1 = k;
      end
      prev_hs = hs;
      if (de && int'(x) > max_x) max_x = int'(x);
      if (de && int'(y) > max_y) max_y = int'(y);
`ifdef VIDEO_TPG_EN
      if (k == 0)  chk("tpg_x0", 64'(vout_data), 64'hFFFFFF);
      if (k == 2)  chk("tpg_x2", 64'(vout_data), 64'hFFFF00);
      if (k == 15) chk("tpg_x15", 64'(vout_data), 64'h000000);
      if (k == HA) chk("tpg_blank", 64'(vout_data), 64'h0);
`endif
      tick();
    end
    chk("fs_period", 64'(frame_start), 64'd1);
    chk("de_per_frame", 64'(de_cnt), 64'd80);
    chk("de_lines", 64'(lines), 64'd5);
    chk("hs_high_clks", 64'(hs_cnt), 64'd27);
    chk("vs_low_clks", 64'(vs_lo), 64'd46);
    chk("fs_per_frame", 64'(fs_cnt), 64'd1);
    chk("hs_first_rise", 64'(rise0), 64'd18);
    chk("hs_period", 64'(rise1 - rise0), 64'd23);
    chk("max_x", 64'(max_x), 64'd15);
    chk("max_y", 64'(max_y), 64'd4);

    de_cnt = 0; fs_cnt = 0;
    for (int k = 0; k < 500; k++) begin
      if (k == 60) en = 1'b0;
      if (de) de_cnt++;
      if (frame_start) fs_cnt++;
      tick();
    end
    chk("drop_en_de", 64'(de_cnt), 64'd80);
    chk("drop_en_fs", 64'(fs_cnt), 64'd1);
    chk("park", 64'({hs, vs, de}), 64'b010);

    en = 1'b1;
    tick();
    chk("restart_pre", 64'(frame_start), 64'd0);
    tick();
    chk("restart_fs", 64'(frame_start), 64'd1);

    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      if (de && y == 12'd2 && x == 12'd5) found = 1'b1;
      else tick();
    end
    chk("find_mid", 64'(found), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", 64'({hs, vs, de, frame_start}), 64'b0100);
    chk("async_xy", 64'({x, y, vout_data}), 64'd0);
    en = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    de_cnt = 0;
    for (int k = 0; k < 50; k++) begin
      if (de || frame_start) de_cnt++;
      tick();
    end
    chk("post_rst_idle", 64'(de_cnt), 64'd0);
    en = 1'b1;
    tick();
    tick();
    chk("post_rst_fs", 64'(frame_start), 64'd1);

    for (int k = 0; k < 3000; k++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 1499) == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
